mem_access_sequencer: RTL and testbench

//  Clocked multicycle sequencer for load/store/swap datapath: MAR, MDR, RAM, TEMP, register file.

---
 rtl/mem_seq_pkg.sv | 67 ++++++
 rtl/mfc_watchdog.sv | 30 +++
 rtl/mem_access_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared encodings for the load/store/swap memory sequencer: states, op3 classes,
// error codes and ALU operand routes, plus the op3 decode and alignment helpers.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_RD_REQ  = 4'd2,
    S_RD_CAP  = 4'd3,
    S_TMP_CAP = 4'd4,
    S_WR_DATA = 4'd5,
    S_WR_REQ  = 4'd6,
    S_WB      = 4'd7,
    S_DONE    = 4'd8,
    S_ERR     = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    C_ILLEGAL = 2'd0,
    C_LOAD    = 2'd1,
    C_STORE   = 2'd2,
    C_SWAP    = 2'd3
  } op_class_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_OP3     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] DSEL_ADDR  = 2'b00;
  localparam logic [1:0] DSEL_STORE = 2'b01;
  localparam logic [1:0] DSEL_MDR   = 2'b10;
  localparam logic [1:0] DSEL_TEMP  = 2'b11;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_SWAP = 6'b001111;

  // LDD/STD are deliberately absent: double-word transfers are not supported.
  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    case (op)
      OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH: c = C_LOAD;
      OP_ST, OP_STB, OP_STH:                     c = C_STORE;
      OP_SWAP:                                   c = C_SWAP;
      default:                                   c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] lo);
    logic ok;
    case (op)
      OP_LD, OP_ST, OP_SWAP:    ok = (lo == 2'b00);
      OP_LDUH, OP_LDSH, OP_STH: ok = ~lo[0];
      default:                  ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mfc_watchdog.sv
// Counts cycles spent waiting on MFC; expired is high during the final allowed wait cycle.
// Cleared while not waiting, so each RAM request starts from a zero count.
module mfc_watchdog #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic Clk,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// Multicycle MAR/MDR/RAM/TEMP/register-file sequencer for format-3 load, store and swap.
// done pulses 1 (illegal) .. 8 (swap) cycles after start; each MFC wait cycle adds one.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       start,
  input  logic [5:0] op3,
  input  logic [1:0] addr_lo,
  input  logic       MFC,
  output logic       busy,
  output logic       done,
  output logic [1:0] mem_err,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       TEMP_Enable,
  output logic       reg_we,
  output logic [1:0] data_sel
);

  state_e     state_q, state_d;
  logic [5:0] op3_q, op3_d;
  logic [1:0] err_q, err_d;

  op_class_e  cls_q;
  logic       aligned;
  logic       in_req;
  logic       wd_expired;

  assign cls_q   = op_class(op3_q);
  assign aligned = is_aligned(op3_q, addr_lo);
  assign in_req  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);

  mfc_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .Clk     (Clk),
    .RESET   (RESET),
    .clr     (!in_req),
    .en      (in_req),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    op3_d   = op3_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op3_d = op3;
          if (op_class(op3) == C_ILLEGAL) begin
            state_d = S_ERR;
            err_d   = ERR_OP3;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (!aligned) begin
          state_d = S_ERR;
          err_d   = ERR_ALIGN;
        end else if (cls_q == C_STORE) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      // MFC takes priority over the watchdog on the same edge.
      S_RD_REQ: begin
        if (MFC) begin
          state_d = S_RD_CAP;
        end else if (wd_expired) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_RD_CAP:  state_d = (cls_q == C_SWAP) ? S_TMP_CAP : S_WB;
      S_TMP_CAP: state_d = S_WR_DATA;
      S_WR_DATA: state_d = S_WR_REQ;
      S_WR_REQ: begin
        if (MFC) begin
          state_d = (cls_q == C_SWAP) ? S_WB : S_DONE;
        end else if (wd_expired) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      op3_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op3_q   <= op3_d;
      err_q   <= err_d;
    end
  end

  // Outputs follow the state register; only MAR_Enable also looks at the live address.
  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = 1'b0;
    mem_err        = ERR_OK;
    MAR_Enable     = 1'b0;
    MDR_Enable     = 1'b0;
    MDR_Mux_select = 1'b0;
    RAM_enable     = 1'b0;
    RAM_OpCode     = (state_q != S_IDLE) ? op3_q : 6'b0;
    TEMP_Enable    = 1'b0;
    reg_we         = 1'b0;
    data_sel       = DSEL_ADDR;
    case (state_q)
      S_ADDR:    MAR_Enable = aligned;
      S_RD_REQ: begin
        RAM_enable     = 1'b1;
        MDR_Mux_select = 1'b1;
      end
      S_RD_CAP: begin
        MDR_Enable     = 1'b1;
        MDR_Mux_select = 1'b1;
      end
      S_TMP_CAP: begin
        TEMP_Enable = 1'b1;
        data_sel    = DSEL_MDR;
      end
      S_WR_DATA: begin
        MDR_Enable = 1'b1;
        data_sel   = DSEL_STORE;
      end
      S_WR_REQ:  RAM_enable = 1'b1;
      S_WB: begin
        reg_we   = 1'b1;
        data_sel = (cls_q == C_SWAP) ? DSEL_TEMP : DSEL_MDR;
      end
      S_DONE:    done = 1'b1;
      S_ERR: begin
        done    = 1'b1;
        mem_err = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench: each transaction is expanded into the per-cycle output trace the
// sequencer must produce, and a negedge process compares the DUT against it.
module tb_mem_access_sequencer;

  localparam int TMO = 15;

  logic       Clk = 1'b0;
  logic       RESET;
  logic       start;
  logic [5:0] op3;
  logic [1:0] addr_lo;
  logic       MFC;
  logic       busy, done, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, TEMP_Enable, reg_we;
  logic [1:0] mem_err, data_sel;
  logic [5:0] RAM_OpCode;

  mem_access_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
    .Clk(Clk), .RESET(RESET), .start(start), .op3(op3), .addr_lo(addr_lo), .MFC(MFC),
    .busy(busy), .done(done), .mem_err(mem_err), .MAR_Enable(MAR_Enable),
    .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select), .RAM_enable(RAM_enable),
    .RAM_OpCode(RAM_OpCode), .TEMP_Enable(TEMP_Enable), .reg_we(reg_we), .data_sel(data_sel)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic       mar;
    logic       mdr;
    logic       msel;
    logic       ram;
    logic [5:0] opc;
    logic       temp;
    logic       we;
    logic [1:0] dsel;
  } exp_t;

  exp_t act;
  assign act = {busy, done, mem_err, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable,
                RAM_OpCode, TEMP_Enable, reg_we, data_sel};

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t tr_exp[$];
  logic tr_mfc[$];
  logic [5:0] legal_ops[9] = '{6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010,
                               6'b000100, 6'b000101, 6'b000110, 6'b001111};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  // 0 illegal, 1 load, 2 store, 3 swap
  function automatic int kind(input logic [5:0] o);
    case (o)
      6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010: return 1;
      6'b000100, 6'b000101, 6'b000110:                       return 2;
      6'b001111:                                             return 3;
      default:                                               return 0;
    endcase
  endfunction

  function automatic bit al(input logic [5:0] o, input logic [1:0] a);
    if (o == 6'b000000 || o == 6'b000100 || o == 6'b001111) return a == 2'b00;
    if (o == 6'b000010 || o == 6'b001010 || o == 6'b000110) return a[0] == 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input exp_t r, input logic m);
    tr_exp.push_back(r);
    tr_mfc.push_back(m);
  endtask

  // RAM request of up to TMO cycles; MFC is driven high from wait index d onward.
  task automatic req(input exp_t base, input int d, input logic rd, output bit ok);
    exp_t r;
    for (int i = 0; i < TMO; i++) begin
      r = base; r.ram = 1'b1; r.msel = rd;
      push(r, i >= d);
      if (i >= d) begin ok = 1'b1; return; end
    end
    r = base; r.done = 1'b1; r.err = 2'b11;
    push(r, 1'($urandom));
    ok = 1'b0;
  endtask

  task automatic build(input logic [5:0] o, input logic [1:0] a, input int drd, input int dwr);
    exp_t base, r;
    bit ok;
    int k;
    tr_exp.delete(); tr_mfc.delete();
    k = kind(o);
    base = '0; base.busy = 1'b1; base.opc = o;
    if (k == 0) begin
      r = base; r.done = 1'b1; r.err = 2'b10; push(r, 1'($urandom)); return;
    end
    r = base; r.mar = al(o, a); push(r, 1'($urandom));
    if (!al(o, a)) begin
      r = base; r.done = 1'b1; r.err = 2'b01; push(r, 1'($urandom)); return;
    end
    if (k != 2) begin
      req(base, drd, 1'b1, ok);
      if (!ok) return;
      r = base; r.mdr = 1'b1; r.msel = 1'b1; push(r, 1'($urandom));
      if (k == 1) begin
        r = base; r.we = 1'b1; r.dsel = 2'b10; push(r, 1'($urandom));
        r = base; r.done = 1'b1; push(r, 1'($urandom));
        return;
      end
      r = base; r.temp = 1'b1; r.dsel = 2'b10; push(r, 1'($urandom));
    end
    r = base; r.mdr = 1'b1; r.dsel = 2'b01; push(r, 1'($urandom));
    req(base, dwr, 1'b0, ok);
    if (!ok) return;
    if (k == 3) begin
      r = base; r.we = 1'b1; r.dsel = 2'b11; push(r, 1'($urandom));
    end
    r = base; r.done = 1'b1; push(r, 1'($urandom));
  endtask

  task automatic cyc(input exp_t e, input logic s, input logic [5:0] o, input logic [1:0] a,
                     input logic m);
    @(posedge Clk);
    #1;
    exp_q.push_back(e);
    start = s; op3 = o; addr_lo = a; MFC = m;
  endtask

  task automatic run_txn(input logic [5:0] o, input logic [1:0] a, input int drd, input int dwr,
                         input int gap, input int cut);
    int n;
    build(o, a, drd, dwr);
    repeat (gap) cyc('0, 1'b0, 6'($urandom), 2'($urandom), 1'($urandom));
    cyc('0, 1'b1, o, a, 1'($urandom));
    n = (cut < 0) ? tr_exp.size() : cut;
    for (int i = 0; i < n; i++)
      cyc(tr_exp[i], 1'($urandom), 6'($urandom), (i == 0) ? a : 2'($urandom), tr_mfc[i]);
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 14;
      5: return 15;
      6: return 40;
      default: return int'($urandom_range(4, 13));
    endcase
  endfunction

  always @(negedge Clk) begin
    if (exp_q.size() > 0) chk("cycle", act, exp_q.pop_front());
  end

  initial begin
    int n_ram;
    logic [5:0] o;
    RESET = 1'b0; start = 1'b0; op3 = '0; addr_lo = '0; MFC = 1'b0;
    #1;
    chk("reset_state", act, 0);
    repeat (3) @(posedge Clk);
    #3 RESET = 1'b1;

    // Pin the model's traces with hand-computed expectations.
    build(6'b000000, 2'b00, 0, 0);
    chk("pin_load_len", tr_exp.size(), 5);
    chk("pin_load_mar", tr_exp[0].mar, 1);
    chk("pin_load_ram", tr_exp[1].ram, 1);
    chk("pin_load_wb", {tr_exp[3].we, tr_exp[3].dsel}, 3'b110);
    build(6'b000101, 2'b11, 0, 2);
    chk("pin_store_len", tr_exp.size(), 6);
    build(6'b001111, 2'b00, 0, 0);
    chk("pin_swap_len", tr_exp.size(), 8);
    chk("pin_swap_wb", tr_exp[6].dsel, 2'b11);
    build(6'b000010, 2'b01, 0, 0);
    chk("pin_misal", {tr_exp.size() == 2, tr_exp[0].mar, tr_exp[1].err}, 4'b1001);
    build(6'b000011, 2'b00, 0, 0);
    chk("pin_illegal", {tr_exp.size() == 1, tr_exp[0].err}, 3'b110);
    build(6'b000000, 2'b00, 99, 0);
    n_ram = 0;
    foreach (tr_exp[i]) n_ram += tr_exp[i].ram;
    chk("pin_timeout", {n_ram, tr_exp.size(), 30'(tr_exp[16].err)}, {32'd15, 32'd17, 30'd3});

    // Directed scenarios through the DUT.
    run_txn(6'b000000, 2'b00, 0, 0, 0, -1);
    run_txn(6'b000101, 2'b11, 0, 2, 0, -1);
    run_txn(6'b001111, 2'b00, 0, 0, 1, -1);
    run_txn(6'b000010, 2'b01, 0, 0, 0, -1);
    run_txn(6'b000011, 2'b00, 0, 0, 2, -1);
    run_txn(6'b000000, 2'b00, 99, 0, 0, -1);
    run_txn(6'b001111, 2'b00, 14, 14, 0, -1);

    for (int t = 0; t < 200; t++) begin
      o = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 8)] : 6'($urandom);
      run_txn(o, 2'($urandom), pick_delay(), pick_delay(), $urandom_range(0, 2), -1);
    end

    // Reset three cycles into the swap's write request.
    run_txn(6'b001111, 2'b00, 0, 10, 0, 8);
    @(posedge Clk);
    #1 start = 1'b0; MFC = 1'b0;
    #2 RESET = 1'b0;
    #1 chk("reset_mid_swap", act, 0);
    repeat (2) @(posedge Clk);
    #3 RESET = 1'b1;
    chk("reset_held_idle", act, 0);
    run_txn(6'b000000, 2'b00, 1, 0, 0, -1);

    repeat (3) @(posedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
